seven_seg_mux: RTL

Bus-attached, time-multiplexed hex display driver for 1–8 common-anode/cathode digits.
- Registered STB/WE/ACK slave with four word registers: DATA, DP, CTRL and STATUS.
- Full readback of every register.
- Drives Segment/AN directly to board pins.
- Replaces the fixed 4-digit driver, adding per-digit decimal point, per-digit blanking, global enable, polarity selection and a registered handshake.

---
 rtl/seven_seg_mux.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: bus-slave, time-multiplexed hex driver for 1..8 digits (DATA/DP/CTRL/STATUS).
// Latency: ACK and DAT_O one cycle after STB is sampled; pins one cycle after idx change or write.
// Backpressure: none; STB held through ACK is served on alternate cycles, never stalled longer.
// Build option: define SEVEN_SEG_BLINK_EN to add the CTRL blink mask and STATUS blink phase.
module seven_seg_mux #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV_W = 17,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              STB,
  input  logic              WE,
  input  logic [1:0]        ADR_I,
  input  logic [31:0]       DAT_I,
  output logic [31:0]       DAT_O,
  output logic              ACK,
  output logic [7:0]        Segment,
  output logic [DIGITS-1:0] AN
);

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_DP     = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;
  localparam logic [1:0] ADR_STATUS = 2'd3;

  // Output polarity is applied as an XOR mask at the pin register.
  localparam logic [7:0]        SEG_INV  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_INV   = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);
  localparam logic [2:0]        LAST_IDX = 3'(DIGITS - 1);
  // Reset image: digit 0 showing glyph "0" with dp off.
  localparam logic [7:0]        SEG_RST_AH = 8'h3F;

  // Register file
  logic [4*DIGITS-1:0]   r_data;
  logic [DIGITS-1:0]     r_dp;
  logic                  r_en;
  logic [DIGITS-1:0]     r_blank;

  // Scan state
  logic [SCAN_DIV_W-1:0] r_presc;
  logic [2:0]            r_idx;

  // Bus and pin registers
  logic                  r_ack;
  logic [31:0]           r_dat_o;
  logic [7:0]            r_seg;
  logic [DIGITS-1:0]     r_an;

  // Combinational helpers
  logic                  w_access;
  logic                  w_wr;
  logic                  w_tick;
  logic [31:0]           w_rd_dat;
  logic [3:0]            w_nib;
  logic                  w_dp_bit;
  logic                  w_blank_bit;
  logic                  w_blink_off;
  logic                  w_dark;
  logic [7:0]            w_seg_ah;
  logic [DIGITS-1:0]     w_an_ah;
  logic                  w_unused;

`ifdef SEVEN_SEG_BLINK_EN
  localparam int BLINK_W = SCAN_DIV_W + 6;
  logic [DIGITS-1:0]     r_blink;
  logic [BLINK_W-1:0]    r_blink_cnt;
  logic                  r_phase;
  logic                  w_blink_bit;
`endif

  // Hex glyph lookup, active-high gfedcba.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // An access is only taken when the previous one is not still being acknowledged.
  assign w_access = STB && !r_ack;
  assign w_wr     = w_access && WE;
  assign w_tick   = &r_presc;

  // Bits of DAT_I beyond the implemented fields are deliberately dropped.
  assign w_unused = ^DAT_I;

  // Read mux: unimplemented bits return zero.
  always_comb begin
    w_rd_dat = 32'h0;
    case (ADR_I)
      ADR_DATA: w_rd_dat[4*DIGITS-1:0] = r_data;
      ADR_DP:   w_rd_dat[DIGITS-1:0]   = r_dp;
      ADR_CTRL: begin
        w_rd_dat[0]           = r_en;
        w_rd_dat[8 +: DIGITS] = r_blank;
`ifdef SEVEN_SEG_BLINK_EN
        w_rd_dat[16 +: DIGITS] = r_blink;
`endif
      end
      default: begin
        w_rd_dat[2:0] = r_idx;
`ifdef SEVEN_SEG_BLINK_EN
        w_rd_dat[8] = r_phase;
`endif
      end
    endcase
  end

  // Handshake: ACK pulses one cycle per sampled access; DAT_O holds between accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack   <= 1'b0;
      r_dat_o <= 32'h0;
    end else begin
      r_ack <= w_access;
      if (w_access) begin
        r_dat_o <= w_rd_dat;
      end
    end
  end

  // Register writes land on the same edge that raises ACK; STATUS writes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_dp    <= '0;
      r_en    <= 1'b1;
      r_blank <= '0;
`ifdef SEVEN_SEG_BLINK_EN
      r_blink <= '0;
`endif
    end else if (w_wr) begin
      case (ADR_I)
        ADR_DATA: r_data <= DAT_I[4*DIGITS-1:0];
        ADR_DP:   r_dp   <= DAT_I[DIGITS-1:0];
        ADR_CTRL: begin
          r_en    <= DAT_I[0];
          r_blank <= DAT_I[8 +: DIGITS];
`ifdef SEVEN_SEG_BLINK_EN
          r_blink <= DAT_I[16 +: DIGITS];
`endif
        end
        default: ;
      endcase
    end
  end

  // Prescaler free-runs; each wrap advances the digit index, wrapping at the last digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= 3'd0;
    end else begin
      r_presc <= r_presc + SCAN_DIV_W'(1);
      if (w_tick) begin
        r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
      end
    end
  end

`ifdef SEVEN_SEG_BLINK_EN
  // Blink phase flips each time the long counter wraps (every 2^(SCAN_DIV_W+6) cycles).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      if (&r_blink_cnt) begin
        r_phase <= ~r_phase;
      end
    end
  end
`endif

  // Select the per-digit fields for the digit currently being scanned.
  always_comb begin
    w_nib       = 4'h0;
    w_dp_bit    = 1'b0;
    w_blank_bit = 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
    w_blink_bit = 1'b0;
`endif
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == 3'(k)) begin
        w_nib       = r_data[4*k +: 4];
        w_dp_bit    = r_dp[k];
        w_blank_bit = r_blank[k];
`ifdef SEVEN_SEG_BLINK_EN
        w_blink_bit = r_blink[k];
`endif
      end
    end
  end

`ifdef SEVEN_SEG_BLINK_EN
  assign w_blink_off = w_blink_bit && r_phase;
`else
  assign w_blink_off = 1'b0;
`endif

  // A dark digit drives neither anode nor segments, so nothing ghosts between digits.
  assign w_dark   = !r_en || w_blank_bit || w_blink_off;
  assign w_seg_ah = w_dark ? 8'h00 : {w_dp_bit, hex_glyph(w_nib)};
  assign w_an_ah  = w_dark ? '0 : (AN_ONE << r_idx);

  // Pin register: one glitch-free update per cycle, polarity applied here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= SEG_RST_AH ^ SEG_INV;
      r_an  <= AN_ONE ^ AN_INV;
    end else begin
      r_seg <= w_seg_ah ^ SEG_INV;
      r_an  <= w_an_ah ^ AN_INV;
    end
  end

  assign ACK     = r_ack;
  assign DAT_O   = r_dat_o;
  assign Segment = r_seg;
  assign AN      = r_an;

endmodule
